// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator and its neighbours.
// Contains the load-source select encodings and the default widths.
// The instruction decoder and the datapath use the same values.
package accumulator_pkg;

  // Default widths of the accumulator and of the instruction immediate.
  localparam int ACC_W = 16;
  localparam int IMM_W = 8;

  // Encodings for the selacc input.
  localparam logic [1:0] SEL_IMM  = 2'b00;  // zero-extended immediate
  localparam logic [1:0] SEL_RD   = 2'b01;  // register-file read data
  localparam logic [1:0] SEL_RES  = 2'b10;  // ALU/FPU result
  localparam logic [1:0] SEL_HOLD = 2'b11;  // keep the current value

endpackage : accumulator_pkg

// File: rtl/accumulator.sv
// Purpose: single accumulator register that loads from one of three sources.
// Latency: a load sampled at a rising edge is visible on acc_data immediately after that edge.
// Backpressure: none; a load is taken on every edge where loadacc=1, and the register holds otherwise.
//
// Ports:
//   clk       - single clock; all state changes on the rising edge
//   rstn      - synchronous reset, active HIGH despite the name; clears the register
//   loadacc   - load enable for the next rising edge
//   selacc    - load-source select (SEL_IMM / SEL_RD / SEL_RES / SEL_HOLD)
//   immediate - immediate operand, zero-extended to DATA_W when loaded
//   rd_data   - register-file read data, loaded bit-exact
//   res_out   - ALU/FPU result, loaded bit-exact
//   acc_data  - register contents, driven straight from the flop
module accumulator #(
  parameter int DATA_W = accumulator_pkg::ACC_W,
  parameter int IMM_W  = accumulator_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              loadacc,
  input  logic [1:0]        selacc,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] res_out,
  output logic [DATA_W-1:0] acc_data
);

  import accumulator_pkg::*;

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_next;

  // Next-value mux. SEL_HOLD and any unknown select fall into the hold
  // branch, so a bad select can never corrupt the register.
  always_comb begin
    acc_next = acc_q;
    case (selacc)
      SEL_IMM:  acc_next = DATA_W'(immediate);  // size cast zero-extends
      SEL_RD:   acc_next = rd_data;
      SEL_RES:  acc_next = res_out;
      default:  acc_next = acc_q;
    endcase
  end

  // Reset takes priority over a pending load on the same edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      acc_q <= '0;
    end else if (loadacc) begin
      acc_q <= acc_next;
    end
  end

  assign acc_data = acc_q;

endmodule : accumulator

// File: tb/tb_accumulator.sv
// Scoreboard bench for the accumulator.
// The stimulus process drives inputs at the falling edge and queues the value acc_data must show after the next rising edge.
// The monitor pops and compares that value just after each rising edge.
module tb_accumulator;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              loadacc;
  logic [1:0]        selacc;
  logic [IMM_W-1:0]  immediate;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] res_out;
  logic [DATA_W-1:0] acc_data;

  always #5 clk = ~clk;

  accumulator #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .loadacc   (loadacc),
    .selacc    (selacc),
    .immediate (immediate),
    .rd_data   (rd_data),
    .res_out   (res_out),
    .acc_data  (acc_data)
  );

  typedef struct {
    logic [DATA_W-1:0] exp;
    string             name;
  } exp_t;

  exp_t              sb_q[$];
  int                checks   = 0;
  int                failures = 0;
  logic [DATA_W-1:0] model;
  bit                model_valid = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: acc_data=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference behaviour: reset clears the register; otherwise a load picks one of
  // {zero-extended immediate, rd_data, res_out, current value}; no load keeps the value.
  function automatic logic [DATA_W-1:0] ref_next(input bit r, input bit l,
      input logic [1:0] s, input logic [IMM_W-1:0] imm,
      input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] res,
      input logic [DATA_W-1:0] cur);
    logic [DATA_W-1:0] src [4];
    src[0] = {8'h00, imm};
    src[1] = rd;
    src[2] = res;
    src[3] = cur;
    if (r)  return '0;
    if (!l) return cur;
    return src[s];
  endfunction

  // One clock of stimulus. The inputs change between edges, so acc_data must not
  // move until the next rising edge. That is checked right after the drive.
  task automatic cycle(input bit r, input bit l, input logic [1:0] s,
                       input logic [IMM_W-1:0] imm, input logic [DATA_W-1:0] rd,
                       input logic [DATA_W-1:0] res, input string name);
    @(negedge clk);
    rstn      = r;
    loadacc   = l;
    selacc    = s;
    immediate = imm;
    rd_data   = rd;
    res_out   = res;
    #1;
    if (model_valid) check({name, "_between_edges"}, acc_data, model);
    model       = ref_next(r, l, s, imm, rd, res, model_valid ? model : '0);
    model_valid = 1'b1;
    sb_q.push_back('{exp: model, name: name});
  endtask

  // Monitor: each rising edge produces one expected acc_data value.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, acc_data, e.exp);
      end
    end
  end

  initial begin
    rstn = 1'b1; loadacc = 1'b0; selacc = 2'b00;
    immediate = '0; rd_data = '0; res_out = '0;

    // Reset wins over a pending load of res_out.
    cycle(1, 1, 2'b10, 8'h00, 16'h0000, 16'h1234, "reset_over_load");
    // Immediate loads, zero-extended.
    cycle(0, 1, 2'b00, 8'd90, 16'h7777, 16'h8888, "imm_90");
    cycle(0, 1, 2'b00, 8'hFF, 16'h7777, 16'h8888, "imm_ff_zext");
    // rd_data load, then stable across a second edge.
    cycle(0, 1, 2'b01, 8'h33, 16'd78, 16'h4444, "rd_78");
    cycle(0, 1, 2'b01, 8'h33, 16'd78, 16'h4444, "rd_78_stable");
    // res_out load.
    cycle(0, 1, 2'b10, 8'h12, 16'h5555, 16'd9998, "res_9998");
    // Hold with loadacc=0 while every other input toggles.
    for (int i = 0; i < 3; i++)
      cycle(0, 0, 2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom),
            16'($urandom), "hold_noload");
    // Hold via the SEL_HOLD select.
    cycle(0, 1, 2'b11, 8'hAB, 16'hCDEF, 16'h0123, "hold_sel11");
    // Reset mid-operation, then release with a pending rd_data load.
    cycle(0, 1, 2'b10, 8'h00, 16'h0000, 16'hFFFF, "res_ffff");
    cycle(1, 1, 2'b01, 8'h00, 16'hA5A5, 16'h0000, "reset_mid_op");
    cycle(0, 1, 2'b01, 8'h00, 16'hA5A5, 16'h0000, "rd_a5a5_after_reset");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
            2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom),
            16'($urandom), "random");

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_accumulator

// File: doc/accumulator.md
ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 Parameter DATA_W, default 16: width of the accumulator register, rd_data, res_out and acc_data.
REQ-002 Parameter IMM_W, default 8: width of the immediate input; IMM_W SHALL be less than or equal to DATA_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-high (asserted when 1, despite the name).
REQ-005 loadacc  input  1  load enable; 1 = update the register at the next rising edge.
REQ-006 selacc  input  2  load-source select.
REQ-007 immediate  input  IMM_W  immediate operand from the instruction word.
REQ-008 rd_data  input  DATA_W  register-file read data.
REQ-009 res_out  input  DATA_W  ALU/FPU result.
REQ-010 acc_data  output  DATA_W  current accumulator contents, driven directly from the register.

Function
REQ-011 The block SHALL contain one DATA_W-bit register, acc_q, and acc_data SHALL equal acc_q at all times (no combinational path from inputs).
REQ-012 On a rising edge with rstn=0 and loadacc=1, acc_q SHALL take a value chosen by selacc:
- 2'b00 -> immediate, zero-extended to DATA_W
- 2'b01 -> rd_data
- 2'b10 -> res_out
- 2'b11 -> acc_q (hold)
REQ-013 On a rising edge with rstn=0 and loadacc=0, acc_q SHALL hold its value regardless of selacc and the data inputs.
REQ-014 Load latency SHALL be one cycle: a value sampled at edge N is visible on acc_data immediately after edge N and remains until the next qualifying edge.
REQ-015 Values SHALL be loaded unmodified: no sign extension, saturation or arithmetic; rd_data and res_out are passed through bit-exact.
REQ-016 Changes on selacc or the data inputs between edges SHALL have no effect on acc_data.
REQ-017 An X or unknown value on selacc with loadacc=1 SHALL NOT be relied on; in RTL, the 2'b11/default branch SHALL be the hold branch.

Reset
REQ-018 When rstn=1 at a rising edge, acc_q SHALL become 0, overriding loadacc and selacc.
REQ-019 Reset SHALL be synchronous only; asserting rstn between edges SHALL NOT change acc_data until the next rising edge.
REQ-020 Asserting reset during a pending load (loadacc=1 and rstn=1 on the same edge) SHALL yield 0, and the load is discarded.
REQ-021 Before the first reset edge, acc_data is undefined; benches SHALL apply reset for at least one edge.

Structure
REQ-022 A shared package SHALL hold the selacc encodings as named constants: SEL_IMM=2'b00, SEL_RD=2'b01, SEL_RES=2'b10, SEL_HOLD=2'b11.
REQ-023 The package SHALL also hold the default widths ACC_W=16 and IMM_W=8, shared with the decoder and datapath.
REQ-024 The block SHALL be a single module with one combinational next-value mux and one clocked register process; no sub-module is required.

Verification
REQ-025 Reset: apply rstn=1 for one edge with loadacc=1 and selacc=2'b10, res_out=16'h1234 -> acc_data=0.
REQ-026 Immediate load: rstn=0, immediate=8'd90, selacc=2'b00, loadacc=1, one edge -> acc_data=16'd90; then immediate=8'hFF -> acc_data=16'h00FF (zero-extended).
REQ-027 rd_data and res_out loads:
- rd_data=16'd78, selacc=2'b01, loadacc=1 -> acc_data=16'd78 after one edge and stable over a second edge.
- res_out=16'd9998, selacc=2'b10 -> acc_data=16'd9998.
REQ-028 Hold cases:
- With acc_data=16'd9998, loadacc=0 for 3 edges while toggling selacc and all data inputs -> acc_data stays 9998.
- selacc=2'b11 with loadacc=1 -> acc_data also stays 9998.
REQ-029 Reset mid-operation: with acc_data=16'hFFFF, assert rstn=1 between edges -> no change before the edge, 0 after it; deassert with a pending load of rd_data=16'hA5A5 -> acc_data=16'hA5A5 on the following edge.
